// File: rtl/parking_gate_arbiter.sv
// Purpose : arbitrates the single parking barrier between the entrance and exit lanes,
//           times the open gate, and keeps the occupancy count behind the "full" flag.
// Latency : a grant is visible one cycle after the request is sampled in IDLE; a pass or
//           timeout closes the gate on the next edge, followed by one CLOSE and one IDLE cycle.
// Backpressure: requests are level-held by the lane logic and are only sampled in IDLE;
//           a lane that is full/empty simply waits, nothing is queued or dropped.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   entry_req, exit_req   level requests from the lane sensor / password logic
//   pass_done             one-cycle pulse, car cleared the barrier (only honoured while open)
//   gate_open             barrier open command
//   grant_entry/exit      which lane currently owns the open gate
//   full, occupancy       car count and its "reached CAPACITY" flag
//   timeout               one-cycle pulse during CLOSE when the gate shut without a pass
module parking_gate_arbiter #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_done,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             full,
  output logic [CNT_W-1:0] occupancy,
  output logic             timeout
);

  // Timer only has to reach OPEN_CYCLES-1, so clog2 bits are enough.
  localparam int TMR_W = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_ENT = 2'd1,
    OPEN_EXT = 2'd2,
    CLOSE    = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             last_exit;   // 1: most recent grant went to the exit lane

  logic ent_elig;
  logic ext_elig;
  logic any_elig;
  logic pick_exit;
  logic close_now;

  // full is a pure decode of the count register so it tracks occupancy with no lag.
  assign full = (occupancy == CAP_V);

  // A full lot blocks the entrance and an empty lot blocks the exit; this is what
  // keeps occupancy inside 0..CAPACITY without any saturation logic.
  assign ent_elig = entry_req & ~full;
  assign ext_elig = exit_req & (occupancy != '0);
  assign any_elig = ent_elig | ext_elig;

  // Exit wins if it is the only eligible lane, or on a tie when the entrance
  // had the previous grant (round-robin).
  assign pick_exit = ext_elig & (~ent_elig | ~last_exit);

  // A pass on the last open cycle still counts as a pass, so pass_done is
  // checked before the timer expiry when deciding between count and timeout.
  assign close_now = pass_done | (timer == TMR_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      last_exit   <= 1'b1;
      occupancy   <= '0;
      gate_open   <= 1'b0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      // timeout is a single-cycle pulse; only the expiry branch re-raises it.
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (any_elig) begin
            state       <= pick_exit ? OPEN_EXT : OPEN_ENT;
            gate_open   <= 1'b1;
            grant_entry <= ~pick_exit;
            grant_exit  <= pick_exit;
            last_exit   <= pick_exit;
            timer       <= '0;
          end
        end

        OPEN_ENT, OPEN_EXT: begin
          // Requests are not looked at here: the gate stays with its owner
          // until the car passes or the timer runs out.
          if (close_now) begin
            state       <= CLOSE;
            gate_open   <= 1'b0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            if (pass_done) begin
              if (state == OPEN_ENT) begin
                occupancy <= occupancy + ONE;
              end else begin
                occupancy <= occupancy - ONE;
              end
            end else begin
              timeout <= 1'b1;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        CLOSE: begin
          // One guaranteed closed cycle before arbitration resumes.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
module tb_parking_gate_arbiter;

  localparam int CAP = 8;
  localparam int CW  = 4;
  localparam int OC  = 16;

  logic          clk;
  logic          reset_n;
  logic          entry_req;
  logic          exit_req;
  logic          pass_done;
  logic          gate_open;
  logic          grant_entry;
  logic          grant_exit;
  logic          full;
  logic [CW-1:0] occupancy;
  logic          timeout;

  parking_gate_arbiter #(
    .CAPACITY   (CAP),
    .CNT_W      (CW),
    .OPEN_CYCLES(OC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .pass_done  (pass_done),
    .gate_open  (gate_open),
    .grant_entry(grant_entry),
    .grant_exit (grant_exit),
    .full       (full),
    .occupancy  (occupancy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One expected gate session: which lane, how many cycles open, whether it
  // ended in a timeout, and the occupancy once the gate has closed.
  typedef struct {
    bit lane;   // 0 entrance, 1 exit
    int len;
    bit to;
    int occ;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: lot occupancy and who was served last.
  int m_occ;
  bit m_last_exit;

  // Present a request for one cycle in IDLE; if a lane is granted, pulse
  // pass_done on open cycle d (d >= OC means no pass, i.e. timeout).
  task automatic do_txn(input bit er, input bit xr, input int d);
    bit   ent_el, ext_el, lane;
    int   len;
    exp_t e;
    @(negedge clk);
    entry_req = er;
    exit_req  = xr;
    pass_done = 1'b0;
    ent_el = er && (m_occ < CAP);
    ext_el = xr && (m_occ > 0);
    if (!ent_el && !ext_el) begin
      @(negedge clk);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      chk("no_grant_gate", gate_open, 0);
      chk("no_grant_lane", grant_entry | grant_exit, 0);
      pass_done = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      pass_done = 1'b0;
      return;
    end
    lane = (ent_el && ext_el) ? !m_last_exit : ext_el;
    m_last_exit = lane;
    len = (d < OC) ? d + 1 : OC;
    if (d < OC) m_occ = lane ? m_occ - 1 : m_occ + 1;
    e.lane = lane;
    e.len  = len;
    e.to   = (d >= OC);
    e.occ  = m_occ;
    exp_q.push_back(e);
    // Open cycles 0..len-1, then the CLOSE cycle (index len).
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      pass_done = (i == d);
    end
    // First IDLE cycle: occasional stray pulse that must be ignored.
    @(negedge clk);
    pass_done = ($urandom_range(0, 3) == 0);
  endtask

  task automatic reset_mid_open();
    exp_t e;
    @(negedge clk);
    entry_req = 1'b0;
    exit_req  = 1'b1;
    pass_done = 1'b0;
    e.lane = 1'b1; e.len = 0; e.to = 1'b0; e.occ = 0;
    exp_q.push_back(e);   // session is aborted by reset; monitor drops it
    @(negedge clk);
    exit_req = 1'b0;
    @(negedge clk);
    chk("pre_reset_open", gate_open, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_gate", gate_open, 0);
    chk("arst_grant_entry", grant_entry, 0);
    chk("arst_grant_exit", grant_exit, 0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_full", full, 0);
    chk("arst_timeout", timeout, 0);
    m_occ = 0;
    m_last_exit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: follows the gate and scores each completed session against the queue.
  initial begin
    bit   tracking;
    bit   lane_seen;
    int   cnt;
    exp_t e;
    tracking  = 1'b0;
    lane_seen = 1'b0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        if (tracking && exp_q.size() != 0) e = exp_q.pop_front();
        tracking = 1'b0;
      end else if (gate_open) begin
        if (!tracking) begin
          tracking  = 1'b1;
          cnt       = 1;
          lane_seen = grant_exit;
          chk("grant_onehot", grant_entry ^ grant_exit, 1);
          if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
        end else begin
          cnt++;
          chk("grant_held", grant_exit, lane_seen);
        end
        chk("timeout_while_open", timeout, 0);
      end else if (tracking) begin
        tracking = 1'b0;
        if (exp_q.size() == 0) begin
          chk("session_without_expect", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("lane", lane_seen, e.lane);
          chk("open_len", cnt, e.len);
          chk("timeout_pulse", timeout, e.to);
          chk("occupancy", occupancy, e.occ);
          chk("full", full, (e.occ == CAP));
        end
      end else begin
        chk("timeout_idle", timeout, 0);
      end
    end
  end

  initial begin
    int d;
    bit er, xr;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    pass_done = 1'b0;
    reset_n   = 1'b0;
    m_occ       = 0;
    m_last_exit = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gate", gate_open, 0);
    chk("rst_grant_entry", grant_entry, 0);
    chk("rst_grant_exit", grant_exit, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_full", full, 0);
    chk("rst_timeout", timeout, 0);
    reset_n = 1'b1;

    do_txn(0, 1, 0);                 // exit at empty lot: no grant
    do_txn(1, 0, 3);                 // entry, pass 3 cycles after grant
    do_txn(1, 0, 0);
    do_txn(1, 0, 1);
    do_txn(0, 1, 0);                 // occupancy 2, last grant = exit
    repeat (4) do_txn(1, 1, 1);      // ties: entry, exit, entry, exit
    repeat (6) do_txn(1, 0, 0);      // fill to capacity
    do_txn(1, 0, 0);                 // full: entrance blocked
    chk("full_at_capacity", full, (m_occ == CAP));
    do_txn(1, 1, 2);                 // only exit eligible
    do_txn(1, 0, 0);                 // entrance served again
    do_txn(0, 1, 0);
    do_txn(1, 0, OC + 1);            // timeout, no count change
    do_txn(1, 0, OC - 1);            // pass on final open cycle wins
    repeat (3) do_txn(0, 1, 0);      // down to 5
    reset_mid_open();
    do_txn(0, 1, 0);                 // empty again after reset

    for (int n = 0; n < 250; n++) begin
      er = ($urandom_range(0, 9) < 7);
      xr = ($urandom_range(0, 9) < 7);
      d  = ($urandom_range(0, 7) == 0) ? $urandom_range(OC - 2, OC + 1) : $urandom_range(0, 4);
      do_txn(er, xr, d);
    end

    @(negedge clk);
    pass_done = 1'b0;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_occupancy", occupancy, m_occ);
    chk("final_full", full, (m_occ == CAP));
    chk("final_gate", gate_open, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
